// File: rtl/music_sequencer.sv
// Song player: steps through a 16-entry note ROM at BEAT_DIV cycles per step, with play/pause/stop control.
// Optional macro NOTE_GAP_EN silences the last GAP_CYC cycles of every step.
module music_sequencer #(
  parameter int BEAT_DIV = 25_000_000,
  parameter int GAP_CYC  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_pulse,
  input  logic        stop_pulse,
  input  logic        loop,
  output logic [21:0] note_div_left,
  output logic [3:0]  note_idx,
  output logic        playing,
  output logic        song_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [24:0] LP_LAST      = 25'(BEAT_DIV - 1);
  localparam logic [24:0] LP_GAP_START = 25'(BEAT_DIV - GAP_CYC);
`ifdef NOTE_GAP_EN
  localparam logic LP_GAP_EN = 1'b1;
`else
  localparam logic LP_GAP_EN = 1'b0;
`endif

  state_t      r_state;
  logic [24:0] r_beat_cnt;
  logic [3:0]  r_note_idx;
  logic [21:0] r_note_div;
  logic        r_playing;
  logic        r_song_done;

  logic        w_step_end;
  logic        w_gap;
  logic [21:0] w_note_next;

  function automatic logic [3:0] song_code(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd14:   song_code = 4'd1;
      4'd2, 4'd3, 4'd6:    song_code = 4'd5;
      4'd4, 4'd5:          song_code = 4'd6;
      4'd8, 4'd9:          song_code = 4'd4;
      4'd10, 4'd11:        song_code = 4'd3;
      4'd12, 4'd13:        song_code = 4'd2;
      default:             song_code = 4'd0;
    endcase
  endfunction

  function automatic logic [21:0] tone_div(input logic [3:0] code);
    case (code)
      4'd1:    tone_div = 22'd191570;
      4'd2:    tone_div = 22'd170648;
      4'd3:    tone_div = 22'd151515;
      4'd4:    tone_div = 22'd143266;
      4'd5:    tone_div = 22'd127551;
      4'd6:    tone_div = 22'd113636;
      4'd7:    tone_div = 22'd101215;
      4'd9:    tone_div = 22'd95420;
      4'd10:   tone_div = 22'd85034;
      4'd11:   tone_div = 22'd75758;
      4'd12:   tone_div = 22'd71633;
      4'd13:   tone_div = 22'd63776;
      4'd14:   tone_div = 22'd56818;
      4'd15:   tone_div = 22'd50607;
      default: tone_div = 22'd0;
    endcase
  endfunction

  assign w_step_end = (r_beat_cnt == LP_LAST);
  assign w_gap      = LP_GAP_EN & (r_beat_cnt >= LP_GAP_START);

  // Tone for the next output cycle; silent outside PLAY and inside the gap.
  always_comb begin
    w_note_next = 22'd0;
    if ((r_state == ST_PLAY) && !w_gap) begin
      w_note_next = tone_div(song_code(r_note_idx));
    end else begin
      w_note_next = 22'd0;
    end
  end

  // Transport FSM, beat/step counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= 25'd0;
      r_note_idx  <= 4'd0;
      r_note_div  <= 22'd0;
      r_playing   <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_note_div  <= w_note_next;
      r_song_done <= 1'b0;
      if (stop_pulse) begin
        r_state    <= ST_IDLE;
        r_beat_cnt <= 25'd0;
        r_note_idx <= 4'd0;
        r_playing  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (play_pulse) begin
              r_state    <= ST_PLAY;
              r_beat_cnt <= 25'd0;
              r_note_idx <= 4'd0;
              r_playing  <= 1'b1;
            end else begin
              r_playing  <= 1'b0;
            end
          end
          ST_PLAY: begin
            r_beat_cnt <= w_step_end ? 25'd0 : (r_beat_cnt + 25'd1);
            if (w_step_end && (r_note_idx == 4'd15) && !loop) begin
              r_state     <= ST_IDLE;
              r_note_idx  <= 4'd0;
              r_playing   <= 1'b0;
              r_song_done <= 1'b1;
            end else begin
              // Index 15 naturally wraps to 0 when looping.
              if (w_step_end) begin
                r_note_idx <= r_note_idx + 4'd1;
              end
              if (play_pulse) begin
                r_state   <= ST_PAUSE;
                r_playing <= 1'b0;
              end else begin
                r_playing <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (play_pulse) begin
              r_state   <= ST_PLAY;
              r_playing <= 1'b1;
            end else begin
              r_playing <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 25'd0;
            r_note_idx <= 4'd0;
            r_playing  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_div_left = r_note_div;
  assign note_idx      = r_note_idx;
  assign playing       = r_playing;
  assign song_done     = r_song_done;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock, 100 MHz); rst input 1 (synchronous, active-high reset).
REQ-002 Parameter BEAT_DIV, default 25_000_000: clk cycles per song step.
REQ-003 Parameter GAP_CYC, default 2_500_000: silent cycles at the end of each step; must be less than BEAT_DIV.
REQ-004 Ports SHALL be, one per line:
- play_pulse  input  1  one-cycle pulse: IDLE to PLAY, PLAY to PAUSE, PAUSE to PLAY.
- stop_pulse  input  1  one-cycle pulse: return to IDLE.
- loop  input  1  level: repeat the song at its end.
- note_div_left  output  22  tone divider to the note display and the speaker stage; 0 = silence.
- note_idx  output  4  current song step.
- playing  output  1  high in PLAY.
- song_done  output  1  one-cycle pulse at the end of a non-looped song.

Function
REQ-005 FSM states SHALL be IDLE, PLAY and PAUSE; state encoding is free.
REQ-006 Song ROM SHALL hold 16 entries of 4-bit note codes, index 0..15: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0.
REQ-007 Code mapping SHALL be:
- 0 and 8 -> 0 (rest).
- 1..7 -> 191570, 170648, 151515, 143266, 127551, 113636, 101215.
- 9..15 -> 95420, 85034, 75758, 71633, 63776, 56818, 50607.
REQ-008 beat_cnt SHALL be a 25-bit counter that increments only in PLAY and wraps to 0 after BEAT_DIV-1; the wrap cycle is the step end.
REQ-009 At a step end with note_idx<15, note_idx SHALL increment.
REQ-010 At a step end with note_idx=15 and loop=1, note_idx SHALL become 0 and the state SHALL stay PLAY.
REQ-011 At a step end with note_idx=15 and loop=0: state SHALL become IDLE, note_idx 0, and song_done SHALL be 1 for exactly the next cycle.
REQ-012 note_div_left SHALL be registered, with 1-cycle latency from state, note_idx and beat_cnt.
REQ-013 note_div_left SHALL equal the ROM mapping of note_idx in PLAY, and 0 in IDLE and PAUSE.
REQ-014 In PAUSE, beat_cnt and note_idx SHALL hold; resuming SHALL continue from the held beat_cnt.
REQ-015 stop_pulse in any state SHALL give IDLE, note_idx 0 and beat_cnt 0 on the next edge.
REQ-016 If stop_pulse and play_pulse are high together, stop SHALL win.
REQ-017 play_pulse from IDLE SHALL enter PLAY with beat_cnt 0 and note_idx 0.
REQ-018 playing SHALL be registered and high exactly while state is PLAY.
REQ-019 play_pulse coinciding with a step end in PLAY SHALL enter PAUSE with the step advance applied.

Reset
REQ-020 On rst=1 at a clk edge, the block SHALL set: state IDLE, beat_cnt 0, note_idx 0, note_div_left 0, playing 0, song_done 0.
REQ-021 rst SHALL take priority over all other inputs, including mid-step in PLAY.

Configuration
REQ-022 Feature macro NOTE_GAP_EN SHALL control the inter-note gap.
REQ-023 With NOTE_GAP_EN defined, in PLAY note_div_left SHALL be 0 while beat_cnt >= BEAT_DIV-GAP_CYC.
REQ-024 Without NOTE_GAP_EN, no gap SHALL be inserted and GAP_CYC SHALL be unused.

Verification
REQ-025 Benches SHALL use BEAT_DIV=8, GAP_CYC=2 and cover these directed scenarios:
- Reset, then play_pulse: note_div_left=191570 two cycles after the pulse; note_idx steps 0->1 after 8 cycles; playing=1.
- NOTE_GAP_EN defined: note_div_left=0 on the output cycles following beat_cnt=6,7; 191570 again at the next step start. Undefined: no zero cycles.
- play_pulse at beat_cnt=3, step 4: 2 cycles of PAUSE give note_div_left=0 and note_idx=4; next play_pulse resumes at beat_cnt=3 with output 113636.
- loop=0: after 128 PLAY cycles, song_done pulses for 1 cycle, state is IDLE, note_idx=0. loop=1: note_idx wraps 15->0 and playing stays 1.
- stop_pulse with play_pulse at step 9 -> IDLE, note_idx=0, note_div_left=0 next cycle.
- rst asserted at step 5 mid-beat -> all outputs 0 on the next cycle; play_pulse restarts at step 0.
